mctp_tx_arb: RTL and testbench

MCTP_TX_ARB -- requirements
Module: mctp_tx_arb

---
 rtl/mctp_tx_arb.sv | 110 +++++++++++
 tb/tb_mctp_tx_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mctp_tx_arb.sv
// mctp_tx_arb: round-robin arbiter sending one MCTP packet at a time from two requesters onto AXI AW/W/B
module mctp_tx_arb #(
  parameter logic [63:0] P_ADDR0 = 64'h0,
  parameter logic [63:0] P_ADDR1 = 64'h1000
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [15:0]  i_req_len,
  input  logic [255:0] i_req_hdr,
  input  logic [511:0] i_wdata,
  input  logic [1:0]   i_wvalid,
  output logic [1:0]   o_wready,
  output logic [6:0]   O_AWID,
  output logic [63:0]  O_AWADDR,
  output logic [7:0]   O_AWLEN,
  output logic [2:0]   O_AWSIZE,
  output logic [1:0]   O_AWBURST,
  output logic         O_AWVALID,
  input  logic         I_AWREADY,
  output logic [255:0] O_WDATA,
  output logic [31:0]  O_WSTRB,
  output logic         O_WLAST,
  output logic         O_WVALID,
  input  logic         I_WREADY,
  input  logic [6:0]   I_BID,
  input  logic [1:0]   I_BRESP,
  input  logic         I_BVALID,
  output logic         O_BREADY,
  output logic [1:0]   o_done,
  output logic [1:0]   o_err
);
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  state_t          state_q;
  logic            gnt_q, last_q, gnt_d, awvalid_q, in_w, wlast;
  logic [1:0][1:0] seq_q;
  logic [7:0]      len_q, beat_q;
  logic [127:0]    hdr_q, hdr_s, hdr_d;
  logic [255:0]    wd_g;
  logic [1:0]      req_ready_q, done_q, err_q, gnt_oh;
  assign gnt_d  = (&i_req_valid) ? ~last_q : i_req_valid[1];
  assign hdr_s  = gnt_d ? i_req_hdr[255:128] : i_req_hdr[127:0];
  assign hdr_d  = {hdr_s[127:126], seq_q[gnt_d], hdr_s[123:0]};
  assign gnt_oh = gnt_q ? 2'b10 : 2'b01;
  assign wd_g   = gnt_q ? i_wdata[511:256] : i_wdata[255:0];
  assign in_w   = state_q == W;
  assign wlast  = beat_q == len_q;
  assign O_AWVALID   = awvalid_q;
  assign O_AWID      = {6'b0, awvalid_q & gnt_q};
  assign O_AWADDR    = awvalid_q ? (gnt_q ? P_ADDR1 : P_ADDR0) : 64'h0;
  assign O_AWLEN     = awvalid_q ? len_q : 8'h0;
  assign O_AWSIZE    = awvalid_q ? 3'd5 : 3'd0;
  assign O_AWBURST   = {1'b0, awvalid_q};
  assign O_WVALID    = in_w & i_wvalid[gnt_q];
  assign o_wready    = (in_w & I_WREADY) ? gnt_oh : 2'b00;
  assign O_WLAST     = in_w & wlast;
  assign O_WSTRB     = {32{in_w}};
  // beat 0 carries the header in its low half
  assign O_WDATA     = !in_w ? 256'h0 : beat_q == 8'h0 ? {wd_g[255:128], hdr_q} : wd_g;
  assign O_BREADY    = state_q == B;
  assign o_req_ready = req_ready_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      seq_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      hdr_q       <= '0;
      req_ready_q <= '0;
      awvalid_q   <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      req_ready_q <= '0;
      done_q      <= '0;
      err_q       <= '0;
      case (state_q)
        IDLE: if (|i_req_valid) begin
          gnt_q          <= gnt_d;
          last_q         <= gnt_d;
          req_ready_q    <= gnt_d ? 2'b10 : 2'b01;
          len_q          <= gnt_d ? i_req_len[15:8] : i_req_len[7:0];
          hdr_q          <= hdr_d;
          seq_q[gnt_d]   <= seq_q[gnt_d] + 2'd1;
          beat_q         <= '0;
          awvalid_q      <= 1'b1;
          state_q        <= AW;
        end
        AW: if (I_AWREADY) begin
          awvalid_q <= 1'b0;
          state_q   <= W;
        end
        W: if (O_WVALID && I_WREADY) begin
          beat_q <= beat_q + 8'd1;
          if (wlast) state_q <= B;
        end
        B: if (I_BVALID) begin
          done_q  <= gnt_oh;
          err_q   <= (I_BRESP != 2'b00 || I_BID != {6'b0, gnt_q}) ? gnt_oh : 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mctp_tx_arb.sv
// tb_mctp_tx_arb: randomized scoreboard bench for mctp_tx_arb against a packet-level reference model
module tb_mctp_tx_arb;
  localparam logic [63:0] A0 = 64'h0, A1 = 64'h1000;
  logic         i_clk = 0, i_reset_n = 0;
  logic [1:0]   i_req_valid = 0, o_req_ready, i_wvalid = 0, o_wready, o_done, o_err;
  logic [15:0]  i_req_len = 0;
  logic [255:0] i_req_hdr = 0, O_WDATA;
  logic [511:0] i_wdata = 0;
  logic [6:0]   O_AWID, I_BID = 0;
  logic [63:0]  O_AWADDR;
  logic [7:0]   O_AWLEN;
  logic [2:0]   O_AWSIZE;
  logic [1:0]   O_AWBURST, I_BRESP = 0;
  logic         O_AWVALID, I_AWREADY = 0, O_WLAST, O_WVALID, I_WREADY = 0, I_BVALID = 0, O_BREADY;
  logic [31:0]  O_WSTRB;

  mctp_tx_arb #(.P_ADDR0(A0), .P_ADDR1(A1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_len(i_req_len), .i_req_hdr(i_req_hdr), .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .O_AWID(O_AWID), .O_AWADDR(O_AWADDR), .O_AWLEN(O_AWLEN), .O_AWSIZE(O_AWSIZE), .O_AWBURST(O_AWBURST),
    .O_AWVALID(O_AWVALID), .I_AWREADY(I_AWREADY), .O_WDATA(O_WDATA), .O_WSTRB(O_WSTRB), .O_WLAST(O_WLAST),
    .O_WVALID(O_WVALID), .I_WREADY(I_WREADY), .I_BID(I_BID), .I_BRESP(I_BRESP), .I_BVALID(I_BVALID),
    .O_BREADY(O_BREADY), .o_done(o_done), .o_err(o_err));

  always #5 i_clk = ~i_clk;

  typedef struct { logic [7:0] len; logic [127:0] hdr; } desc_t;
  typedef struct { logic g; logic [7:0] len; logic [127:0] hdr; } pkt_t;

  int total = 0, bad = 0;
  desc_t dq [2][$];
  desc_t cur [2];
  pkt_t  awq[$], wq[$], pq[$];
  logic  bq[$];
  logic [3:0] eq[$];
  logic [1:0] pres = 0, acc = 0, prev_v = 0;
  logic  m_last = 1;
  int    m_seq [2] = '{0, 0};
  int    wbeat = 0, pbeat = 0, awcnt = 0, aw_lat = 0, b_mode = 0;
  logic  have = 0, w_acc = 0, aw_stall = 0, w_stall = 0;
  logic  req_gap = 0, w_gap = 0, wr_rand = 0, aw_rand = 0;
  logic [255:0] aw_snap, w_snap;

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  always @(posedge i_clk) prev_v = i_req_valid;

  // requester descriptor sources
  initial forever begin
    @(posedge i_clk); #1;
    for (int r = 0; r < 2; r++) begin
      if (!i_reset_n) pres[r] = 0;
      else begin
        if (acc[r]) begin pres[r] = 0; acc[r] = 0; end
        if (!pres[r] && dq[r].size() > 0 && (!req_gap || $urandom_range(3) != 0)) begin
          cur[r] = dq[r].pop_front();
          pres[r] = 1;
        end
      end
    end
    i_req_valid = pres;
    i_req_len = {cur[1].len, cur[0].len};
    i_req_hdr = {cur[1].hdr, cur[0].hdr};
  end

  // payload source: holds each beat until accepted, the other lane toggles randomly
  initial forever begin
    int g;
    @(posedge i_clk); #1;
    if (!i_reset_n) i_wvalid = 0;
    else begin
      if (w_acc) begin
        w_acc = 0; have = 0; pbeat++;
        if (pbeat > int'(pq[0].len)) begin void'(pq.pop_front()); pbeat = 0; end
      end
      g = pq.size() > 0 ? int'(pq[0].g) : -1;
      for (int r = 0; r < 2; r++)
        if (r != g) begin
          i_wvalid[r] = 1'($urandom_range(1));
          i_wdata[256*r +: 256] = rnd256();
        end else begin
          if (!have) begin i_wdata[256*r +: 256] = rnd256(); have = 1; end
          i_wvalid[r] = w_gap ? ($urandom_range(3) != 0) : 1'b1;
        end
    end
  end

  // AW/W ready drivers
  initial forever begin
    @(posedge i_clk); #1;
    if (!O_AWVALID) begin awcnt = 0; if (aw_rand) aw_lat = $urandom_range(3); end
    else awcnt++;
    I_AWREADY = awcnt > aw_lat;
    I_WREADY = wr_rand ? 1'($urandom_range(1)) : 1'b1;
  end

  // B responder: expected completion is derived from the response it issues
  initial forever begin
    logic bg;
    int m;
    logic err;
    @(posedge i_clk); #1;
    I_BVALID = 0;
    if (i_reset_n && bq.size() > 0 && O_BREADY && $urandom_range(2) == 0) begin
      bg = bq.pop_front();
      m = b_mode == 3 ? ($urandom_range(3) == 0 ? $urandom_range(1, 2) : 0) : b_mode;
      I_BRESP = m == 1 ? 2'($urandom_range(1, 3)) : 2'b00;
      I_BID = m == 2 ? ({6'b0, bg} ^ 7'(1 << $urandom_range(6))) : {6'b0, bg};
      I_BVALID = 1;
      err = I_BRESP != 2'b00 || I_BID != {6'b0, bg};
      eq.push_back({err ? (bg ? 2'b10 : 2'b01) : 2'b00, bg ? 2'b10 : 2'b01});
    end
  end

  // monitor
  initial forever begin
    pkt_t p;
    logic g;
    logic [255:0] e, aw_now;
    logic [3:0] de;
    @(negedge i_clk);
    if (i_reset_n) begin
      if (o_req_ready != 0) begin
        g = prev_v == 2'b11 ? !m_last : prev_v[1];
        chk("grant", o_req_ready, g ? 2'b10 : 2'b01);
        m_last = g;
        p.g = g; p.len = cur[g].len; p.hdr = cur[g].hdr;
        p.hdr[125:124] = 2'(m_seq[g]);
        m_seq[g] = (m_seq[g] + 1) % 4;
        awq.push_back(p); pq.push_back(p);
        acc = acc | o_req_ready;
      end
      aw_now = {O_AWID, O_AWADDR, O_AWLEN, O_AWSIZE, O_AWBURST};
      if (O_AWVALID) begin
        if (awq.size() == 0) chk("aw_unexpected", O_AWVALID, 0);
        else begin
          p = awq[0];
          if (aw_stall) chk("aw_stable", aw_now, aw_snap);
          if (I_AWREADY) begin
            chk("awaddr", O_AWADDR, p.g ? A1 : A0);
            chk("awlen", O_AWLEN, p.len);
            chk("awsize", O_AWSIZE, 3'd5);
            chk("awburst", O_AWBURST, 2'b01);
            chk("awid", O_AWID, {6'b0, p.g});
            wq.push_back(awq.pop_front());
            aw_stall = 0;
          end else begin aw_stall = 1; aw_snap = aw_now; end
        end
      end
      if (O_WVALID) begin
        if (wq.size() == 0) chk("w_unexpected", O_WVALID, 0);
        else begin
          p = wq[0];
          if (w_stall) chk("w_stable", O_WDATA ^ {255'b0, O_WLAST}, w_snap);
          if (I_WREADY) begin
            e = p.g ? i_wdata[511:256] : i_wdata[255:0];
            if (wbeat == 0) e[127:0] = p.hdr;
            chk("wdata", O_WDATA, e);
            chk("wlast", O_WLAST, wbeat == int'(p.len));
            chk("wstrb", O_WSTRB, 32'hFFFFFFFF);
            chk("wready", o_wready, p.g ? 2'b10 : 2'b01);
            w_stall = 0;
            wbeat++;
            if (wbeat > int'(p.len)) begin void'(wq.pop_front()); wbeat = 0; bq.push_back(p.g); end
          end else begin w_stall = 1; w_snap = O_WDATA ^ {255'b0, O_WLAST}; end
        end
      end
      if (pq.size() > 0 && i_wvalid[pq[0].g] && o_wready[pq[0].g]) w_acc = 1;
      if (o_done != 0 || o_err != 0) begin
        if (eq.size() == 0) chk("done_unexpected", {o_err, o_done}, 0);
        else begin
          de = eq.pop_front();
          chk("done", o_done, de[1:0]);
          chk("err", o_err, de[3:2]);
        end
      end
    end
  end

  task automatic chk_zero(input string n);
    chk({n, "_aw"}, {O_AWID, O_AWADDR, O_AWLEN, O_AWSIZE, O_AWBURST, O_AWVALID}, 0);
    chk({n, "_wdata"}, O_WDATA, 0);
    chk({n, "_wctl"}, {O_WSTRB, O_WLAST, O_WVALID, O_BREADY}, 0);
    chk({n, "_ctl"}, {o_req_ready, o_wready, o_done, o_err}, 0);
  endtask

  task automatic do_reset();
    i_reset_n = 0;
    for (int r = 0; r < 2; r++) dq[r].delete();
    awq.delete(); wq.delete(); pq.delete(); bq.delete(); eq.delete();
    pres = 0; acc = 0; have = 0; w_acc = 0; pbeat = 0; wbeat = 0; aw_stall = 0; w_stall = 0;
    m_last = 1; m_seq = '{0, 0};
    #1 chk_zero("reset");
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1;
  endtask

  task automatic push(input int r, input int len);
    desc_t d;
    d.len = 8'(len);
    d.hdr = rnd256()[127:0];
    dq[r].push_back(d);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((dq[0].size() + dq[1].size() + awq.size() + wq.size() + pq.size() + bq.size() + eq.size()) != 0 || pres != 0) begin
      @(posedge i_clk);
      n++;
      if (n > lim) break;
    end
    chk("idle_timeout", n > lim, 0);
    repeat (3) @(posedge i_clk);
  endtask

  initial begin
    int n;
    do_reset();
    // single requester 0, len 1, everything ready
    push(0, 1);
    wait_idle(200);
    // continuous contention, single-beat packets: grants alternate and seq wraps
    do_reset();
    for (int i = 0; i < 5; i++) begin push(0, 0); push(1, 0); end
    wait_idle(500);
    // AW stalled 5 cycles, WREADY toggling, payload gaps
    aw_lat = 5; wr_rand = 1; w_gap = 1;
    push(1, 6);
    push(0, 3);
    wait_idle(500);
    aw_lat = 0;
    // error responses: bad BRESP then BID mismatch
    b_mode = 1; push(0, 2); wait_idle(300);
    b_mode = 2; push(1, 0); wait_idle(300);
    b_mode = 0;
    // reset in the middle of the W phase
    push(0, 7);
    n = 0;
    while (!O_WVALID && n < 300) begin @(negedge i_clk); n++; end
    chk("w_phase_timeout", n >= 300, 0);
    #2 do_reset();
    push(0, 1); push(1, 2);
    wait_idle(300);
    // randomized traffic
    req_gap = 1; aw_rand = 1; b_mode = 3;
    for (int i = 0; i < 40; i++) push($urandom_range(1), $urandom_range(7));
    wait_idle(5000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
